// File: rtl/pwm_seq_ctrl_if.sv
// ============================================================================
// Module  : pwm_seq_ctrl_if
// Brief   : Simple register-bus bundle (chip select / ack handshake).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_seq_ctrl_if;
  logic        cs;
  logic        wr;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (output cs, wr, addr, wdata, be, input rdata, ack);
  modport slave  (input cs, wr, addr, wdata, be, output rdata, ack);
endinterface

`default_nettype wire

// File: rtl/pwm_seq_ctrl.sv
// ============================================================================
// Module  : pwm_seq_ctrl
// Brief   : PWM duty-table sequencer sharing the PWM register bus with the host.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_seq_ctrl #(
  parameter int         TBL_DEPTH   = 8,
  parameter logic [1:0] DUTY_OFFSET = 2'b01
) (
  input  logic                 mclk,
  input  logic                 h_reset_n,
  pwm_seq_ctrl_if.slave        h_bus,
  pwm_seq_ctrl_if.master       m_bus,
  input  logic                 cfg_seq_enb,
  input  logic [1:0]           cfg_seq_chan,
  input  logic [2:0]           cfg_seq_len,
  input  logic                 cfg_seq_loop,
  input  logic                 tbl_we,
  input  logic [2:0]           tbl_waddr,
  input  logic [31:0]          tbl_wdata,
  input  logic [5:0]           pwm_ovflow,
  output logic [2:0]           seq_idx,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic                 seq_miss
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOST = 2'd1,
    ST_SEQ  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic        yield_q, yield_d;
  logic [2:0]  seq_idx_q, seq_idx_d;
  logic        seq_busy_q, seq_busy_d;
  logic        seq_done_q, seq_done_d;
  logic        seq_miss_q, seq_miss_d;
  logic [5:0]  ovf_prev_q;
  logic        enb_prev_q;
  logic [31:0] seq_wdata_q, seq_wdata_d;
  logic [4:0]  seq_addr_q, seq_addr_d;
  logic [2:0]  seq_len_q, seq_len_d;
  logic [31:0] tbl_q [TBL_DEPTH];

  logic enb_rise;
  logic ovf_evt;
  logic seq_ack;
  logic at_end;

  always_comb begin
    enb_rise = cfg_seq_enb & ~enb_prev_q;
    ovf_evt  = seq_busy_q & (cfg_seq_chan != 2'd3) &
               pwm_ovflow[cfg_seq_chan] & ~ovf_prev_q[cfg_seq_chan];
    seq_ack  = (state_q == ST_SEQ) & m_bus.ack;
    // A shortened length (len below the current index) is treated as the end.
    at_end   = (seq_idx_q >= seq_len_q);

    state_d    = state_q;
    pend_d     = pend_q;
    yield_d    = yield_q & pend_q;
    seq_idx_d  = seq_idx_q;
    seq_busy_d = seq_busy_q;
    seq_done_d = 1'b0;
    seq_miss_d = 1'b0;
    seq_wdata_d = seq_wdata_q;
    seq_addr_d  = seq_addr_q;
    seq_len_d   = seq_len_q;

    case (state_q)
      ST_IDLE: begin
        // After a host cycle that overlapped a pending update, the sequencer goes first.
        if (h_bus.cs && !(yield_q && pend_q)) begin
          state_d = ST_HOST;
        end else if (pend_q) begin
          state_d     = ST_SEQ;
          yield_d     = 1'b0;
          seq_wdata_d = tbl_q[seq_idx_q];
          seq_addr_d  = {({1'b0, cfg_seq_chan} + 3'd1), DUTY_OFFSET};
          seq_len_d   = cfg_seq_len;
        end
      end
      ST_HOST: begin
        if (m_bus.ack) begin
          state_d = ST_IDLE;
          yield_d = pend_q;
        end
      end
      ST_SEQ: begin
        if (m_bus.ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (seq_ack) begin
      pend_d = 1'b0;
    end
    if (ovf_evt) begin
      seq_miss_d = pend_q & ~seq_ack;
      pend_d     = 1'b1;
    end

    if (seq_ack && seq_busy_q && cfg_seq_enb) begin
      if (!at_end) begin
        seq_idx_d = seq_idx_q + 3'd1;
      end else if (cfg_seq_loop) begin
        seq_idx_d = 3'd0;
      end else begin
        seq_done_d = 1'b1;
        seq_busy_d = 1'b0;
      end
    end

    if (!cfg_seq_enb) begin
      seq_busy_d = 1'b0;
      pend_d     = 1'b0;
    end else if (enb_rise && (cfg_seq_chan != 2'd3)) begin
      seq_busy_d = 1'b1;
      seq_idx_d  = 3'd0;
      pend_d     = 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      yield_q     <= 1'b0;
      seq_idx_q   <= 3'd0;
      seq_busy_q  <= 1'b0;
      seq_done_q  <= 1'b0;
      seq_miss_q  <= 1'b0;
      ovf_prev_q  <= 6'd0;
      enb_prev_q  <= 1'b0;
      seq_wdata_q <= 32'd0;
      seq_addr_q  <= 5'd0;
      seq_len_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      yield_q     <= yield_d;
      seq_idx_q   <= seq_idx_d;
      seq_busy_q  <= seq_busy_d;
      seq_done_q  <= seq_done_d;
      seq_miss_q  <= seq_miss_d;
      ovf_prev_q  <= pwm_ovflow;
      enb_prev_q  <= cfg_seq_enb;
      seq_wdata_q <= seq_wdata_d;
      seq_addr_q  <= seq_addr_d;
      seq_len_q   <= seq_len_d;
    end
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        tbl_q[i] <= 32'd0;
      end
    end else if (tbl_we) begin
      tbl_q[tbl_waddr] <= tbl_wdata;
    end
  end

  always_comb begin
    m_bus.cs    = 1'b0;
    m_bus.wr    = 1'b0;
    m_bus.addr  = 5'd0;
    m_bus.wdata = 32'd0;
    m_bus.be    = 4'd0;
    h_bus.rdata = 32'd0;
    h_bus.ack   = 1'b0;
    case (state_q)
      ST_HOST: begin
        m_bus.cs    = h_bus.cs;
        m_bus.wr    = h_bus.wr;
        m_bus.addr  = h_bus.addr;
        m_bus.wdata = h_bus.wdata;
        m_bus.be    = h_bus.be;
        h_bus.rdata = m_bus.rdata;
        h_bus.ack   = m_bus.ack;
      end
      ST_SEQ: begin
        m_bus.cs    = 1'b1;
        m_bus.wr    = 1'b1;
        m_bus.addr  = seq_addr_q;
        m_bus.wdata = seq_wdata_q;
        m_bus.be    = 4'hF;
      end
      default: ;
    endcase
  end

  assign seq_idx  = seq_idx_q;
  assign seq_busy = seq_busy_q;
  assign seq_done = seq_done_q;
  assign seq_miss = seq_miss_q;

endmodule

`default_nettype wire

// File: doc/pwm_seq_ctrl.md
Name: pwm_seq_ctrl

Overview:
Duty-cycle sequencer and register-bus arbiter that sits in front of the PWM block's register bus. It is a pass-through for the host register bus. It also autonomously rewrites the duty register of one selected PWM channel from an 8-entry table on every overflow of that channel, giving ramp and pattern generation without CPU involvement. Host and sequencer share the single downstream bus under a fair arbiter.

Parameters:
TBL_DEPTH, 8, number of duty table entries (index width 3)
DUTY_OFFSET, 2'b01, word offset of the duty register inside a PWM channel's register window (m_addr[1:0])

Ports:
mclk  in  1  system clock
h_reset_n  in  1  reset, asynchronous, active-low
h_cs  in  1  host chip select; held until h_ack
h_wr  in  1  host write (1) / read (0)
h_addr  in  5  host register address
h_wdata  in  32  host write data
h_be  in  4  host byte enables
h_rdata  out  32  host read data
h_ack  out  1  host acknowledge, 1-cycle pulse
m_cs  out  1  downstream chip select to PWM block
m_wr  out  1  downstream write
m_addr  out  5  downstream address
m_wdata  out  32  downstream write data
m_be  out  4  downstream byte enables
m_rdata  in  32  downstream read data
m_ack  in  1  downstream acknowledge
cfg_seq_enb  in  1  sequencer enable; rising edge restarts the table
cfg_seq_chan  in  2  target channel 0..2 (value 3 treated as disabled)
cfg_seq_len  in  3  last table index (number of entries minus 1)
cfg_seq_loop  in  1  1 = wrap to entry 0 after the last entry; 0 = stop
tbl_we  in  1  table write strobe
tbl_waddr  in  3  table write index
tbl_wdata  in  32  table write data (duty register value)
pwm_ovflow  in  6  per-channel overflow indications from PWM cores
seq_idx  out  3  next table index to be written
seq_busy  out  1  sequencer active
seq_done  out  1  1-cycle pulse when a non-loop sequence completes
seq_miss  out  1  1-cycle pulse when an overflow arrives while the previous update is still pending

Behaviour:
- Reset (asynchronous, h_reset_n=0) takes effect immediately. Arbiter state goes to IDLE. All m_* outputs, h_ack, h_rdata, seq_idx, seq_busy, seq_done, seq_miss, the pending flag and all table entries are 0.
- Arbiter FSM has three states: IDLE, HOST, SEQ. Priority and transitions:
  - IDLE: if h_cs and not last_was_host_with_pend, go to HOST. Else if pend, go to SEQ. Else stay in IDLE.
  - HOST: m_cs/m_wr/m_addr/m_wdata/m_be are driven combinationally from h_*; h_rdata=m_rdata; h_ack=m_ack. On m_ack, go to IDLE.
  - SEQ: m_cs=1, m_wr=1, m_be=4'hF, m_addr={cfg_seq_chan+1, DUTY_OFFSET}, m_wdata=tbl[seq_idx]. On m_ack, go to IDLE; clear pend; advance the index.
- Fairness: when a HOST transaction completes while pend=1, SEQ is granted next even if h_cs is asserted. An in-flight grant is never pre-empted.
- Outside HOST and SEQ, m_cs=0 and h_ack=0. m_cs deasserts the cycle after m_ack. Host latency is at least 1 cycle (IDLE to HOST) plus the downstream latency.
- Event detection: ovf_evt = pwm_ovflow[cfg_seq_chan] & ~registered previous value (rising edge). It is counted only while seq_busy=1.
- On ovf_evt, pend is set. If pend is already set and not being cleared in the same cycle, seq_miss pulses and pend stays set (no queueing). Simultaneous set and clear: the set wins, no miss.
- Index advance on SEQ ack:
  - If seq_idx != cfg_seq_len, seq_idx increments by 1.
  - Else if cfg_seq_loop=1, seq_idx wraps to 0.
  - Else seq_done pulses, seq_busy clears and seq_idx holds.
- Enable handling:
  - A rising edge of cfg_seq_enb (with cfg_seq_chan != 3) sets seq_busy=1, seq_idx=0 and clears pend.
  - cfg_seq_enb=0 clears seq_busy and pend. A SEQ transaction already granted runs to its ack. Its index advance is suppressed.
  - Restart after done requires deassert then reassert.
- Table writes are single-cycle and effective next cycle. A write to the entry currently being driven in SEQ does not change m_wdata until the next grant, because the entry is latched at grant.
- cfg_seq_len and cfg_seq_chan changes are sampled at SEQ grant and must be changed only while the sequencer is disabled. If cfg_seq_len < seq_idx, the next advance applies the end-of-table rule.

Test Plan:
- Reset mid-HOST transaction (h_cs=1, m_ack pending) -> m_cs=0, h_ack=0 immediately; state IDLE; table reads 0.
- Host write 0x0000_00FF to addr 5'h05 with m_ack after 2 cycles -> m_cs rises 1 cycle after h_cs; m_addr=5'h05; h_ack coincident with m_ack; m_cs low next cycle.
- Table = {10,20,30}, len=2, loop=0, chan=1, enable, 3 overflow pulses on pwm_ovflow[1] -> writes 10,20,30 to m_addr=5'h09; seq_done pulses after the 3rd ack; the 4th overflow produces no bus cycle.
- Same setup with loop=1 and 5 overflows -> data sequence 10,20,30,10,20; seq_idx=2 at the end; no seq_done.
- Two overflows before m_ack (m_ack held off 10 cycles) -> exactly one seq_miss pulse; only one downstream write.
- Host h_cs held continuously while an overflow is pending -> order is HOST, SEQ, HOST; the sequencer is never starved; each h_ack matches its transaction.
